// File: rtl/hamming_frame_encoder.sv
// Hamming(7,4) encoder that packs codewords into frames for the interleaver.
// A flush zero-pads the current partial frame and emits it.
module hamming_frame_encoder #(
    parameter int n          = 7,
    parameter int k          = 4,
    parameter int symbol_num = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [k-1:0]              data_i,
    input  logic                      flush,
    output logic                      rdy,
    output logic                      eno,
    output logic [n*symbol_num-1:0]   data_o
);

    localparam int FW = n * symbol_num;
    localparam int CW = (symbol_num > 1) ? $clog2(symbol_num) : 1;
    localparam logic [CW-1:0] LAST = CW'(symbol_num - 1);

    typedef enum logic {
        FILL,
        PAD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   acc_q, acc_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            eno_q, eno_d;

    logic [n-1:0]    cw;
    logic [n-1:0]    word;
    logic [FW-1:0]   slot_w;
    logic            last;
    logic            p1, p2, p4;

    assign last = (cnt_q == LAST);

    // Hamming(7,4) codeword: positions 1..7 = p1,p2,d1,p4,d2,d3,d4
    always_comb begin
        p1 = data_i[0] ^ data_i[1] ^ data_i[3];
        p2 = data_i[0] ^ data_i[2] ^ data_i[3];
        p4 = data_i[1] ^ data_i[2] ^ data_i[3];
        cw = {data_i[3], data_i[2], data_i[1], p4,
              data_i[0], p2, p1};
    end

    // Accumulator with this cycle's word (codeword or pad zero) in slot cnt
    always_comb begin
        word   = (state_q == FILL) ? cw : '0;
        slot_w = acc_q;
        slot_w[int'(cnt_q)*n +: n] = word;
    end

    // Next-state logic: slot filling, flush to PAD, and frame emit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        frame_d = frame_q;
        eno_d   = 1'b0;
        unique case (state_q)
            FILL: begin
                if (en) begin
                    if (last) begin
                        frame_d = slot_w;
                        eno_d   = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        acc_d = slot_w;
                        cnt_d = cnt_q + CW'(1);
                        if (flush) begin
                            state_d = PAD;
                        end
                    end
                end else if (flush && (cnt_q != '0)) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                if (last) begin
                    frame_d = slot_w;
                    eno_d   = 1'b1;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = FILL;
                end else begin
                    acc_d = slot_w;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State, slot counter, accumulator and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            acc_q   <= '0;
            frame_q <= '0;
            eno_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            frame_q <= frame_d;
            eno_q   <= eno_d;
        end
    end

    assign rdy    = (state_q == FILL);
    assign eno    = eno_q;
    assign data_o = frame_q;

endmodule

// File: tb/tb_hamming_frame_encoder.sv
// Self-checking bench for hamming_frame_encoder.
// Reference model: queue of codewords per frame, Hamming code by position.
module tb_hamming_frame_encoder;

    localparam int N  = 7;
    localparam int K  = 4;
    localparam int SN = 4;
    localparam int FW = N * SN;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [K-1:0]  data_i;
    logic          flush;
    logic          rdy;
    logic          eno;
    logic [FW-1:0] data_o;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  m_cws[$];
    bit            m_pad;
    logic          m_eno;
    logic [FW-1:0] m_data;

    hamming_frame_encoder #(.n(N), .k(K), .symbol_num(SN)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .data_i (data_i),
        .flush  (flush),
        .rdy    (rdy),
        .eno    (eno),
        .data_o (data_o)
    );

    always #5 clk = ~clk;

    // Generic Hamming: data in non-power-of-2 positions, parity i covers
    // every position with bit i set.
    function automatic logic [N-1:0] enc(input logic [3:0] d);
        logic [7:1] w;
        int di;
        bit x;
        w  = '0;
        di = 0;
        for (int p = 1; p <= 7; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p] = d[di];
                di++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            x = 1'b0;
            for (int p = 1; p <= 7; p++) begin
                if (((p >> i) & 1) == 1 && p != (1 << i)) x ^= w[p];
            end
            w[1 << i] = x;
        end
        return w;
    endfunction

    function automatic logic [FW-1:0] pack();
        logic [FW-1:0] f;
        f = '0;
        foreach (m_cws[j]) f[j*N +: N] = m_cws[j];
        return f;
    endfunction

    task automatic model_clear();
        m_cws.delete();
        m_pad  = 1'b0;
        m_eno  = 1'b0;
        m_data = '0;
    endtask

    // Drive one cycle, advance model across the edge, settle 1 time unit.
    task automatic step(input logic e, input logic [3:0] d, input logic f);
        bit was_pad;
        was_pad = m_pad;
        en     = e;
        data_i = d;
        flush  = f;
        @(posedge clk);
        m_eno = 1'b0;
        if (!was_pad) begin
            if (e) begin
                m_cws.push_back(enc(d));
                if (m_cws.size() == SN) begin
                    m_data = pack();
                    m_cws.delete();
                    m_eno = 1'b1;
                end else if (f) begin
                    m_pad = 1'b1;
                end
            end else if (f && m_cws.size() > 0) begin
                m_pad = 1'b1;
            end
        end else begin
            m_cws.push_back('0);
            if (m_cws.size() == SN) begin
                m_data = pack();
                m_cws.delete();
                m_eno = 1'b1;
                m_pad = 1'b0;
            end
        end
        #1;
        en    = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0; flush = 1'b0; data_i = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (data_o !== '0 || eno !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: data_o=%h eno=%b rdy=%b want 0/0/1", data_o, eno, rdy);
        end
        for (int i = 0; i < SN; i++) step(1'b1, 4'($urandom_range(15)), 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 4'hF, 1'b0);
        rst = 1'b1;
        #2;
        checks++;
        if (data_o !== '0 || eno !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: data_o=%h eno=%b rdy=%b want 0/0/1", data_o, eno, rdy);
        end
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 4'h1, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        checks++;
        if (eno !== 1'b1 || data_o !== 28'h0000007) begin
            errors++;
            $display("FAIL reset_fresh: eno=%b data_o=%h want 1/0000007", eno, data_o);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < SN; i++) step(1'b1, 4'hB, 1'b0);
        checks++;
        if (eno !== 1'b1 || data_o !== 28'hAB56AD5) begin
            errors++;
            $display("FAIL single_B: eno=%b data_o=%h want 1/AB56AD5", eno, data_o);
        end
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        step(1'b1, 4'h1, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        checks++;
        if (data_o[6:0] !== 7'h7F || data_o[13:7] !== 7'h00 ||
            data_o[20:14] !== 7'h07) begin
            errors++;
            $display("FAIL single_slots: data_o=%h want slots 7F,00,07", data_o);
        end
    endtask

    task automatic test_full_frame();
        logic [3:0] nib [4];
        nib = '{4'h0, 4'hF, 4'hB, 4'h1};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, nib[i], 1'b0);
            checks++;
            if (eno !== m_eno || data_o !== m_data || rdy !== 1'b1) begin
                errors++;
                $display("FAIL full_step%0d: eno=%b data_o=%h rdy=%b want %b/%h/1",
                         i, eno, data_o, rdy, m_eno, m_data);
            end
        end
        checks++;
        if (eno !== 1'b1 || data_o !== 28'h0F57F80) begin
            errors++;
            $display("FAIL full_frame: eno=%b data_o=%h want 1/0F57F80", eno, data_o);
        end
        step(1'b0, 4'h0, 1'b0);
        checks++;
        if (eno !== 1'b0 || data_o !== 28'h0F57F80) begin
            errors++;
            $display("FAIL full_hold: eno=%b data_o=%h want 0/0F57F80", eno, data_o);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int pos[$];
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'($urandom_range(15)), 1'b0);
            if (eno === 1'b1) begin
                pulses++;
                pos.push_back(i);
            end
            checks++;
            if (eno !== m_eno || data_o !== m_data || rdy !== 1'b1) begin
                errors++;
                $display("FAIL stream_step%0d: eno=%b data_o=%h rdy=%b want %b/%h/1",
                         i, eno, data_o, rdy, m_eno, m_data);
            end
        end
        checks++;
        if (pulses != 3 || pos.size() != 3 || pos[0] != 3 || pos[1] != 7 || pos[2] != 11) begin
            errors++;
            $display("FAIL stream_pulses: got %0d pulses want 3 at steps 3,7,11", pulses);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 4'hB, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        checks++;
        if (rdy !== 1'b0 || eno !== 1'b0) begin
            errors++;
            $display("FAIL flush_pad1: rdy=%b eno=%b want 0/0", rdy, eno);
        end
        step(1'b1, 4'hF, 1'b1);
        checks++;
        if (rdy !== 1'b0 || eno !== 1'b0) begin
            errors++;
            $display("FAIL flush_pad2: rdy=%b eno=%b want 0/0", rdy, eno);
        end
        step(1'b1, 4'hF, 1'b0);
        checks++;
        if (rdy !== 1'b0 || eno !== 1'b0) begin
            errors++;
            $display("FAIL flush_pad3: rdy=%b eno=%b want 0/0", rdy, eno);
        end
        step(1'b0, 4'h0, 1'b0);
        checks++;
        if (eno !== 1'b1 || data_o !== 28'h0000055 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush_emit: eno=%b data_o=%h rdy=%b want 1/0000055/1",
                     eno, data_o, rdy);
        end
    endtask

    task automatic test_flush_edges();
        logic [FW-1:0] held;
        held = data_o;
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b0);
        checks++;
        if (eno !== 1'b0 || rdy !== 1'b1 || data_o !== held) begin
            errors++;
            $display("FAIL flush_empty: eno=%b rdy=%b data_o=%h want 0/1/%h",
                     eno, rdy, data_o, held);
        end
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h9, 1'b0);
        step(1'b1, 4'hC, 1'b1);
        checks++;
        if (eno !== 1'b1 || rdy !== 1'b1 || data_o !== m_data) begin
            errors++;
            $display("FAIL flush_last: eno=%b rdy=%b data_o=%h want 1/1/%h",
                     eno, rdy, data_o, m_data);
        end
        step(1'b0, 4'h0, 1'b0);
        checks++;
        if (eno !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush_last_nopad: eno=%b rdy=%b want 0/1", eno, rdy);
        end
    endtask

    task automatic test_random();
        logic e, f;
        for (int i = 0; i < 400; i++) begin
            e = 1'($urandom_range(3) != 0);
            f = 1'($urandom_range(7) == 0);
            step(e, 4'($urandom_range(15)), f);
            checks++;
            if (eno !== m_eno || data_o !== m_data || rdy !== !m_pad) begin
                errors++;
                $display("FAIL random_step%0d: eno=%b data_o=%h rdy=%b want %b/%h/%b",
                         i, eno, data_o, rdy, m_eno, m_data, !m_pad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_frame();
        test_back_to_back();
        test_flush();
        test_flush_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_frame_encoder.md
Name: hamming_frame_encoder

Overview:
Transmit-side stage directly upstream of the block interleaver. Accepts 4-bit data nibbles over a valid/ready handshake and Hamming(7,4)-encodes each one. Packs symbol_num codewords into one n*symbol_num-bit frame and presents it with a one-cycle eno strobe, which drives the interleaver's en input. A flush input zero-pads and emits a partial frame.

Parameters:
n, 7, codeword length; fixed at 7, because the encoder equations are hard-wired for (7,4)
k, 4, data bits per codeword; fixed at 4
symbol_num, 4, codewords per frame; the frame width is n*symbol_num (28 by default)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  input nibble valid
data_i  input  k  data nibble; bit 0 = d1, bit 3 = d4
flush  input  1  request to zero-pad and emit the current partial frame
rdy  output  1  encoder can accept a nibble this cycle
eno  output  1  one-cycle strobe: data_o holds a new complete frame
data_o  output  n*symbol_num  packed frame of codewords

Behaviour:
- Reset (asynchronous, rst=1):
  - data_o=0, eno=0, rdy=1, slot counter=0, accumulator=0, state=FILL.
  - Reset mid-frame discards the partial frame; no eno is produced for it.
- Codeword layout, bits [6:0] = Hamming positions 1..7 = p1,p2,d1,p4,d2,d3,d4, where:
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p4 = d2^d3^d4
- Frame packing:
  - Codeword in slot j occupies data_o[7j+6:7j].
  - The first nibble accepted after an emit goes to slot 0.
- Accept rule: a nibble is accepted when en=1 and rdy=1 at a rising edge. Data presented while rdy=0 is ignored and not held.
- State FILL (rdy=1):
  - An accept writes the codeword into slot cnt and increments cnt.
  - If cnt==symbol_num-1 on the accept, at that same edge:
    - data_o is loaded with the completed frame (including the new codeword);
    - eno is set to 1 for exactly one cycle;
    - cnt and the accumulator clear.
  - Back-to-back accepts are allowed at one nibble per clock: one frame every symbol_num cycles, with eno high one cycle in each symbol_num.
- Flush handling in FILL:
  - flush=1 while cnt==0 with no accept in the same cycle is ignored.
  - flush=1 with slots remaining after this cycle's accept (if any) goes to PAD at the same edge; rdy=0 from the next cycle.
  - flush=1 on the same edge as the accept that fills the frame causes a normal emit; PAD is not entered.
- State PAD (rdy=0):
  - Each cycle writes an all-zero codeword into slot cnt and increments cnt.
  - When the final slot is written: the emit occurs as above (data_o load, eno pulse, cnt clear), the state returns to FILL and rdy=1 on the following cycle.
  - PAD lasts (symbol_num - filled slots) cycles.
  - flush and en are ignored in PAD.
- eno is registered and is never high two consecutive cycles except on back-to-back full frames with symbol_num=1.
- data_o holds its value between emits; it never changes except at an emit edge or reset.
- Latency: eno is high in the cycle after the edge that accepts the last nibble, or writes the last pad slot.

Test Plan:
- Reset: assert rst mid-frame after 2 accepts -> data_o=0, eno=0, rdy=1; the next 4 nibbles form a fresh frame with the first nibble in slot 0.
- Single codewords: frame 0xB,0xB,0xB,0xB -> slot value 0x55 in each slot, data_o=0xAB56AD5. Nibble 0xF gives slot 0x7F, 0x0 gives 0x00, 0x1 gives 0x07.
- Full frame: nibbles 0x0,0xF,0xB,0x1 on 4 consecutive cycles -> one cycle later eno=1 for one cycle, data_o=0x0F57F80.
- Streaming: 12 consecutive nibbles with en held high -> exactly 3 eno pulses, 4 cycles apart; rdy stays 1 throughout.
- Flush: accept 0xB, then flush=1 with en=0 -> rdy=0 for 3 cycles, then eno=1 with data_o=0x0000055; rdy=1 on the cycle after.
- Flush edge cases:
  - flush with cnt==0 -> no eno, rdy stays 1.
  - flush coincident with the 4th accept -> normal emit, no PAD cycles.
  - en=1 during PAD -> nibble ignored, not present in any frame.
